// File: rtl/timer_pkg.sv
// Shared definitions for the down-timer bank.
// Channel mode encoding used by MODE inputs.
package timer_pkg;

   typedef enum logic {
      MODE_ONESHOT = 1'b0,
      MODE_RELOAD  = 1'b1
   } mode_e;

endpackage

// File: rtl/down_timer_channel.sv
// One timer channel: reload register, saturating down counter,
// RUN flag and registered terminal-count pulse.
module down_timer_channel
   import timer_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             tick,
   input  logic             wr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             ld,
   input  logic             en,
   input  logic             mode,
   output logic [WIDTH-1:0] q,
   output logic             run,
   output logic             tc
);

   logic [WIDTH-1:0] reload;
   logic [WIDTH-1:0] ld_val;
   logic [WIDTH-1:0] q_nxt;
   logic             run_nxt;
   logic             tc_nxt;

   always_ff @(posedge clk) begin
      if (rst) begin
         reload <= '0;
      end else if (wr) begin
         reload <= wr_data;
      end
   end

   always_comb begin
      ld_val  = wr ? wr_data : reload;
      q_nxt   = q;
      run_nxt = run;
      tc_nxt  = 1'b0;
      if (ld) begin
         q_nxt   = ld_val;
         run_nxt = (ld_val != '0);
      end else if (run && en && tick) begin
         if (q > WIDTH'(1)) begin
            q_nxt = q - WIDTH'(1);
         end else begin
            tc_nxt = 1'b1;
            // Auto-reload takes the stored value, never the write bypass.
            if (mode_e'(mode) == MODE_RELOAD) begin
               q_nxt   = reload;
               run_nxt = (reload != '0);
            end else begin
               q_nxt   = '0;
               run_nxt = 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         q   <= '0;
         run <= 1'b0;
         tc  <= 1'b0;
      end else begin
         q   <= q_nxt;
         run <= run_nxt;
         tc  <= tc_nxt;
      end
   end

endmodule

// File: rtl/multi_down_timer.sv
// Bank of NCH down timers sharing one programmable prescaler.
// Prescaler and reload-write decode live here; channels do the rest.
module multi_down_timer
   import timer_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int NCH   = 4,
   parameter int CHW   = 2,
   parameter int PSW   = 8
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic [PSW-1:0]       PSC,
   input  logic                 WR_EN,
   input  logic [CHW-1:0]       WR_CH,
   input  logic [WIDTH-1:0]     WR_DATA,
   input  logic [NCH-1:0]       LD,
   input  logic [NCH-1:0]       EN,
   input  logic [NCH-1:0]       MODE,
   output logic [NCH*WIDTH-1:0] Q,
   output logic [NCH-1:0]       RUN,
   output logic [NCH-1:0]       TC
);

   logic [PSW-1:0] psc_cnt;
   logic           tick;
   logic [NCH-1:0] wr_sel;

   // >= rather than == so lowering PSC never strands the count.
   assign tick = (psc_cnt >= PSC);

   always_ff @(posedge CLK) begin
      if (RST) begin
         psc_cnt <= '0;
      end else if (tick) begin
         psc_cnt <= '0;
      end else begin
         psc_cnt <= psc_cnt + PSW'(1);
      end
   end

   for (genvar i = 0; i < NCH; i++) begin : g_ch
      assign wr_sel[i] = WR_EN && (WR_CH == CHW'(i));

      down_timer_channel #(
         .WIDTH(WIDTH)
      ) u_ch (
         .clk    (CLK),
         .rst    (RST),
         .tick   (tick),
         .wr     (wr_sel[i]),
         .wr_data(WR_DATA),
         .ld     (LD[i]),
         .en     (EN[i]),
         .mode   (MODE[i]),
         .q      (Q[i*WIDTH +: WIDTH]),
         .run    (RUN[i]),
         .tc     (TC[i])
      );
   end

endmodule
